// File: rtl/text_cursor_writer.sv
// Terminal-style character writer: turns an ASCII stream into registered cell writes
// and a cursor highlight for the character memory controller, with a full-screen clear sweep.
module text_cursor_writer #(
  parameter logic [6:0] SPACE      = 7'h20,
  parameter logic [5:0] CLR_COLOUR = 6'b000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       sL,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_ascii,
  input  logic [5:0] in_colour,
  input  logic       clear_req,
  output logic       busy,
  output logic [6:0] wrx,
  output logic [5:0] wry,
  output logic       wren,
  output logic [6:0] wascii,
  output logic [5:0] wcolour,
  output logic [6:0] hix,
  output logic [5:0] hiy,
  output logic       hien,
  output logic       highlight,
  output logic [6:0] cur_x,
  output logic [5:0] cur_y
);

  typedef enum logic [1:0] {S_CLEAR, S_HL_ON, S_IDLE, S_WRITE} state_t;

  state_t     state, state_n;
  logic       sl_q, sl_q_n;
  logic [6:0] clr_x, clr_x_n;
  logic [5:0] clr_y, clr_y_n;
  logic       clr_done, clr_done_n;
  logic       clr_pend, clr_pend_n;
  logic [6:0] cur_x_n, wrx_n, wascii_n, hix_n;
  logic [5:0] cur_y_n, wry_n, wcolour_n, hiy_n;
  logic       wren_n, hien_n, highlight_n;

  logic       start_clear, emit_clear;
  logic [6:0] cell_x;
  logic [5:0] cell_y;
  logic [6:0] last_x;
  logic [5:0] last_y;
  logic [12:0] step;

  assign last_x   = sl_q ? 7'd39 : 7'd79;
  assign last_y   = sl_q ? 6'd29 : 6'd59;
  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_IDLE) && !clr_pend && !clear_req && (sL == sl_q);

  // Row-major step forward with wrap to the top-left cell.
  function automatic logic [12:0] fwd(input logic [6:0] x, input logic [5:0] y,
                                      input logic [6:0] lx, input logic [5:0] ly);
    if (x != lx) return {x + 7'd1, y};
    if (y != ly) return {7'd0, y + 6'd1};
    return 13'd0;
  endfunction

  // Step backward; the top-left cell is sticky.
  function automatic logic [12:0] bwd(input logic [6:0] x, input logic [5:0] y,
                                      input logic [6:0] lx);
    if (x != 7'd0) return {x - 7'd1, y};
    if (y != 6'd0) return {lx, y - 6'd1};
    return 13'd0;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state;
    sl_q_n      = sl_q;
    clr_x_n     = clr_x;
    clr_y_n     = clr_y;
    clr_done_n  = clr_done;
    clr_pend_n  = clr_pend;
    cur_x_n     = cur_x;
    cur_y_n     = cur_y;
    wren_n      = 1'b0;
    wrx_n       = wrx;
    wry_n       = wry;
    wascii_n    = wascii;
    wcolour_n   = wcolour;
    hien_n      = 1'b0;
    hix_n       = hix;
    hiy_n       = hiy;
    highlight_n = 1'b0;
    start_clear = 1'b0;
    emit_clear  = 1'b0;
    cell_x      = clr_x;
    cell_y      = clr_y;
    step        = 13'd0;

    case (state)
      S_CLEAR: begin
        if (sL != sl_q) begin
          start_clear = 1'b1;
        end else if (clr_done) begin
          state_n     = S_HL_ON;
          cur_x_n     = 7'd0;
          cur_y_n     = 6'd0;
          hien_n      = 1'b1;
          hix_n       = 7'd0;
          hiy_n       = 6'd0;
          highlight_n = 1'b1;
        end else begin
          emit_clear = 1'b1;
          clr_done_n = (clr_x == last_x) && (clr_y == last_y);
          {clr_x_n, clr_y_n} = fwd(clr_x, clr_y, last_x, last_y);
        end
      end

      S_WRITE: begin
        state_n     = S_HL_ON;
        hien_n      = 1'b1;
        hix_n       = cur_x;
        hiy_n       = cur_y;
        highlight_n = 1'b1;
        if (clear_req) clr_pend_n = 1'b1;
      end

      S_HL_ON: begin
        state_n = S_IDLE;
        if (clear_req) clr_pend_n = 1'b1;
      end

      default: begin  // S_IDLE
        if (clr_pend || clear_req || (sL != sl_q)) begin
          start_clear = 1'b1;
        end else if (in_valid) begin
          // Old cursor loses its highlight whenever the character moves or writes.
          hix_n = cur_x;
          hiy_n = cur_y;
          case (in_ascii)
            7'h0D: begin
              state_n = S_WRITE;
              hien_n  = 1'b1;
              cur_x_n = 7'd0;
            end
            7'h0A: begin
              state_n = S_WRITE;
              hien_n  = 1'b1;
              cur_x_n = 7'd0;
              cur_y_n = (cur_y == last_y) ? 6'd0 : cur_y + 6'd1;
            end
            7'h08: begin
              state_n   = S_WRITE;
              hien_n    = 1'b1;
              step      = bwd(cur_x, cur_y, last_x);
              {cur_x_n, cur_y_n} = step;
              wren_n    = 1'b1;
              {wrx_n, wry_n} = step;
              wascii_n  = SPACE;
              wcolour_n = CLR_COLOUR;
            end
            7'h0C: start_clear = 1'b1;
            default: begin
              if (in_ascii >= 7'h20 && in_ascii <= 7'h7E) begin
                state_n   = S_WRITE;
                hien_n    = 1'b1;
                wren_n    = 1'b1;
                wrx_n     = cur_x;
                wry_n     = cur_y;
                wascii_n  = in_ascii;
                wcolour_n = in_colour;
                {cur_x_n, cur_y_n} = fwd(cur_x, cur_y, last_x, last_y);
              end
            end
          endcase
        end
      end
    endcase

    // A new sweep emits its first cell on the entry edge itself.
    if (start_clear) begin
      state_n    = S_CLEAR;
      sl_q_n     = sL;
      clr_pend_n = 1'b0;
      clr_done_n = 1'b0;
      clr_x_n    = 7'd1;
      clr_y_n    = 6'd0;
      emit_clear = 1'b1;
      cell_x     = 7'd0;
      cell_y     = 6'd0;
    end

    if (emit_clear) begin
      wren_n      = 1'b1;
      wrx_n       = cell_x;
      wry_n       = cell_y;
      wascii_n    = SPACE;
      wcolour_n   = CLR_COLOUR;
      hien_n      = 1'b1;
      hix_n       = cell_x;
      hiy_n       = cell_y;
      highlight_n = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_CLEAR;
      sl_q      <= 1'b0;
      clr_x     <= 7'd0;
      clr_y     <= 6'd0;
      clr_done  <= 1'b0;
      clr_pend  <= 1'b0;
      cur_x     <= 7'd0;
      cur_y     <= 6'd0;
      wren      <= 1'b0;
      wrx       <= 7'd0;
      wry       <= 6'd0;
      wascii    <= 7'd0;
      wcolour   <= 6'd0;
      hien      <= 1'b0;
      hix       <= 7'd0;
      hiy       <= 6'd0;
      highlight <= 1'b0;
    end else begin
      state     <= state_n;
      sl_q      <= sl_q_n;
      clr_x     <= clr_x_n;
      clr_y     <= clr_y_n;
      clr_done  <= clr_done_n;
      clr_pend  <= clr_pend_n;
      cur_x     <= cur_x_n;
      cur_y     <= cur_y_n;
      wren      <= wren_n;
      wrx       <= wrx_n;
      wry       <= wry_n;
      wascii    <= wascii_n;
      wcolour   <= wcolour_n;
      hien      <= hien_n;
      hix       <= hix_n;
      hiy       <= hiy_n;
      highlight <= highlight_n;
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: a queue of expected per-cycle port activity built from
// linear-index cursor arithmetic, checked every cycle, plus literal spot checks.
module tb_text_cursor_writer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       sL = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_ascii = 7'd0;
  logic [5:0] in_colour = 6'd0;
  logic       clear_req = 1'b0;
  logic       in_ready, busy, wren, hien, highlight;
  logic [6:0] wrx, wascii, hix, cur_x;
  logic [5:0] wry, wcolour, hiy, cur_y;

  text_cursor_writer dut (
    .clock(clock), .resetn(resetn), .sL(sL), .in_valid(in_valid), .in_ready(in_ready),
    .in_ascii(in_ascii), .in_colour(in_colour), .clear_req(clear_req), .busy(busy),
    .wrx(wrx), .wry(wry), .wren(wren), .wascii(wascii), .wcolour(wcolour),
    .hix(hix), .hiy(hiy), .hien(hien), .highlight(highlight),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       wren;
    logic [6:0] wx;
    logic [5:0] wy;
    logic [6:0] wa;
    logic [5:0] wc;
    logic       hien;
    logic [6:0] hx;
    logic [5:0] hy;
    logic       hl;
    logic       busy;
    logic       chk_cur;
    logic [6:0] cx;
    logic [5:0] cy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   checking = 1'b0;
  int   mx = 0, my = 0;       // model cursor
  logic msl = 1'b0;           // model grid select
  int   run = 0;              // consecutive writes since the last write at (0,0)
  logic [6:0] last_wx = 7'd0;
  logic [5:0] last_wy = 6'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int cols_of(input logic s);
    return s ? 40 : 80;
  endfunction

  function automatic int rows_of(input logic s);
    return s ? 30 : 60;
  endfunction

  function automatic exp_t quiet();
    exp_t e;
    e = '0;
    e.chk_cur = 1'b1;
    e.cx = 7'(mx);
    e.cy = 6'(my);
    return e;
  endfunction

  task automatic push_clear();
    exp_t e;
    int c, r;
    c = cols_of(msl);
    r = rows_of(msl);
    for (int i = 0; i < c * r; i++) begin
      e = '0;
      e.wren = 1'b1;
      e.wx = 7'(i % c);
      e.wy = 6'(i / c);
      e.wa = 7'h20;
      e.wc = 6'd0;
      e.hien = 1'b1;
      e.hx = 7'(i % c);
      e.hy = 6'(i / c);
      e.busy = 1'b1;
      q.push_back(e);
    end
    e = '0;
    e.hien = 1'b1;
    e.hl = 1'b1;
    e.busy = 1'b1;
    e.chk_cur = 1'b1;
    q.push_back(e);
    mx = 0;
    my = 0;
  endtask

  task automatic push_char(input logic [6:0] a, input logic [5:0] col);
    exp_t w, h;
    int c, total, idx, nidx;
    bit handled;
    c = cols_of(msl);
    total = c * rows_of(msl);
    idx = my * c + mx;
    nidx = idx;
    handled = 1'b1;
    w = '0;
    if (a >= 7'h20 && a <= 7'h7E) begin
      nidx = (idx + 1) % total;
      w.wren = 1'b1; w.wx = 7'(mx); w.wy = 6'(my); w.wa = a; w.wc = col;
    end else if (a == 7'h0D) begin
      nidx = my * c;
    end else if (a == 7'h0A) begin
      nidx = ((my + 1) % rows_of(msl)) * c;
    end else if (a == 7'h08) begin
      nidx = (idx == 0) ? 0 : idx - 1;
      w.wren = 1'b1; w.wx = 7'(nidx % c); w.wy = 6'(nidx / c); w.wa = 7'h20; w.wc = 6'd0;
    end else begin
      handled = 1'b0;
      if (a == 7'h0C) push_clear();
    end
    if (handled) begin
      w.hien = 1'b1; w.hx = 7'(mx); w.hy = 6'(my); w.hl = 1'b0; w.busy = 1'b1;
      w.chk_cur = 1'b1; w.cx = 7'(nidx % c); w.cy = 6'(nidx / c);
      h = '0;
      h.hien = 1'b1; h.hx = w.cx; h.hy = w.cy; h.hl = 1'b1; h.busy = 1'b1;
      h.chk_cur = 1'b1; h.cx = w.cx; h.cy = w.cy;
      q.push_back(w);
      q.push_back(h);
      mx = nidx % c;
      my = nidx / c;
    end
  endtask

  // Per-cycle compare against the expectation queue, sampled 1 ns after the edge.
  always begin : compare
    exp_t e;
    @(posedge clock);
    #1;
    if (checking) begin
      e = (q.size() > 0) ? q.pop_front() : quiet();
      check("wren", wren, e.wren);
      check("hien", hien, e.hien);
      check("busy", busy, e.busy);
      if (e.wren) check("write", {wrx, wry, wascii, wcolour}, {e.wx, e.wy, e.wa, e.wc});
      if (e.hien) check("hilite", {hix, hiy, highlight}, {e.hx, e.hy, e.hl});
      if (e.chk_cur) check("cursor", {cur_x, cur_y}, {e.cx, e.cy});
    end
    if (wren) begin
      run = (wrx == 7'd0 && wry == 6'd0) ? 1 : run + 1;
      last_wx = wrx;
      last_wy = wry;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain", 32'(q.size() == 0), 32'd1);
    @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] a, input logic [5:0] col);
    in_valid = 1'b1;
    in_ascii = a;
    in_colour = col;
    #1;
    check("ready_at_send", in_ready, 1);
    push_char(a, col);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [6:0] a, input logic [5:0] col);
    send_char(a, col);
    wait_drain(20);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_strobes", {wren, hien, highlight}, 0);
    check("rst_wpos", {wrx, wry}, 0);
    check("rst_hpos", {hix, hiy}, 0);
    check("rst_wdata", {wascii, wcolour}, 0);
    check("rst_cur", {cur_x, cur_y}, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);

    // Power-up clear of the 80x60 grid.
    resetn = 1'b1;
    msl = 1'b0;
    push_clear();
    checking = 1'b1;
    wait_drain(6000);
    check("clr80_run", run, 4800);
    check("clr80_last", {last_wx, last_wy}, {7'd79, 6'd59});
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);

    send_wait(7'h41, 6'h2A);
    check("A_cur", {cur_x, cur_y}, {7'd1, 6'd0});
    send_wait(7'h0D, 6'd0);
    check("CR_cur", {cur_x, cur_y}, 0);
    send_wait(7'h62, 6'h05);
    send_wait(7'h0A, 6'd0);
    check("LF_cur", {cur_x, cur_y}, {7'd0, 6'd1});

    // Switch to 40x30: readiness drops immediately, sweep follows.
    sL = 1'b1;
    #1;
    check("slchg_ready", in_ready, 0);
    msl = 1'b1;
    push_clear();
    wait_drain(2000);
    check("clr40_run", run, 1200);
    check("clr40_last", {last_wx, last_wy}, {7'd39, 6'd29});

    // Walk to the bottom-right corner and wrap.
    repeat (29) send_wait(7'h0A, 6'd0);
    for (int i = 0; i < 39; i++) send_wait(7'(7'h61 + i % 26), 6'(i));
    check("corner_cur", {cur_x, cur_y}, {7'd39, 6'd29});
    send_wait(7'h5A, 6'h15);
    check("Z_cur", {cur_x, cur_y}, 0);
    check("Z_pos", {last_wx, last_wy}, {7'd39, 6'd29});

    repeat (3) send_wait(7'h0A, 6'd0);
    for (int i = 0; i < 5; i++) send_wait(7'h30, 6'h3F);
    send_wait(7'h0A, 6'd0);
    check("LF53_cur", {cur_x, cur_y}, {7'd0, 6'd4});

    repeat (28) send_wait(7'h0A, 6'd0);
    send_wait(7'h08, 6'd0);
    check("BS_cur", {cur_x, cur_y}, {7'd39, 6'd1});
    check("BS_write", {last_wx, last_wy, wascii}, {7'd39, 6'd1, 7'h20});

    send_wait(7'h0D, 6'd0);
    repeat (29) send_wait(7'h0A, 6'd0);
    send_wait(7'h08, 6'd0);
    check("BS00_cur", {cur_x, cur_y}, 0);
    check("BS00_write", {last_wx, last_wy}, 0);

    // clear_req pulsed while the character is being written.
    send_char(7'h51, 6'h11);
    clear_req = 1'b1;
    q.push_back(quiet());
    push_clear();
    @(negedge clock);
    clear_req = 1'b0;
    check("pend_ready1", in_ready, 0);
    @(negedge clock);
    check("pend_ready2", in_ready, 0);
    wait_drain(2000);
    check("pend_run", run, 1200);

    // Grid change mid-sweep restarts it; clear_req mid-sweep is ignored.
    sL = 1'b0;
    msl = 1'b0;
    push_clear();
    repeat (100) @(negedge clock);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (20) @(negedge clock);
    sL = 1'b1;
    q.delete();
    msl = 1'b1;
    push_clear();
    wait_drain(2000);
    check("restart_run", run, 1200);
    check("restart_last", {last_wx, last_wy}, {7'd39, 6'd29});

    send_wait(7'h07, 6'h01);
    check("bel_busy", busy, 0);
    check("bel_cur", {cur_x, cur_y}, 0);

    send_wait(7'h78, 6'h02);
    send_char(7'h0C, 6'd0);
    wait_drain(2000);
    check("ff_run", run, 1200);
    check("ff_cur", {cur_x, cur_y}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream feeder for the character memory controller. Converts a stream of ASCII characters into cell writes, like a terminal.
- Keeps a cursor in the active grid: sL=0 gives 80x60, sL=1 gives 40x30. Handles CR, LF, BS and FF (form feed).
- Moves the single-cell highlight so it follows the cursor.
- Provides a full-screen clear sweep.
- Drives the controller's write and highlight ports directly. Its outputs are registered, so they can tie straight to wrx/wry/wren/wascii/wcolour and hix/hiy/hien/highlight.

Parameters:
- SPACE, 7'h20, ASCII code written by clear and by BS.
- CLR_COLOUR, 6'b000000, colour written by clear and by BS.

Ports:
- clock, input, 1, single clock; also drives wclock/hclock of the controller.
- resetn, input, 1, asynchronous active-low reset.
- sL, input, 1, grid select: 0 = 80x60, 1 = 40x30.
- in_valid, input, 1, character available.
- in_ready, output, 1, writer accepts a character this cycle.
- in_ascii, input, 7, character code.
- in_colour, input, 6, colour for printable characters.
- clear_req, input, 1, request a full clear; level or pulse.
- busy, output, 1, state != S_IDLE.
- wrx, output, 7, write column.
- wry, output, 6, write row.
- wren, output, 1, write strobe.
- wascii, output, 7, write data.
- wcolour, output, 6, write colour.
- hix, output, 7, highlight column.
- hiy, output, 6, highlight row.
- hien, output, 1, highlight write strobe.
- highlight, output, 1, highlight data.
- cur_x, output, 7, current cursor column.
- cur_y, output, 6, current cursor row.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Grid size: COLS/ROWS = 80/60 when sL_q=0, 40/30 when sL_q=1. sL_q is sL registered at the start of each clear.
- Reset (resetn=0): wren=hien=highlight=0; wrx=wry=hix=hiy=wascii=wcolour=0; cur_x=cur_y=0; in_ready=0; clr_pend=0; state=S_CLEAR with sweep counters at (0,0); busy=1.
- States: S_CLEAR, S_HL_ON, S_IDLE, S_WRITE.
- S_CLEAR:
  - One cell per cycle in row-major order, (0,0) to (COLS-1,ROWS-1).
  - Each cycle: wren=1, wascii=SPACE, wcolour=CLR_COLOUR; hien=1, highlight=0 at the same x,y.
  - First write appears in the first cycle after reset release or after clear entry.
  - Takes exactly 4800 cycles (sL_q=0) or 1200 cycles (sL_q=1).
  - Then cur=(0,0), go to S_HL_ON.
  - clear_req during S_CLEAR is ignored. A change of sL during S_CLEAR restarts the sweep at (0,0) with the new sL_q.
- S_HL_ON: one cycle, hien=1, highlight=1 at (cur_x,cur_y), wren=0; then S_IDLE.
- S_IDLE:
  - in_ready=1 unless clr_pend, clear_req, or sL != sL_q.
  - Priority: clear (clr_pend | clear_req | sL != sL_q) wins over any character. It enters S_CLEAR and clears clr_pend.
- Character accept (in_valid & in_ready), cycle T:
  - in_ascii 0x20..0x7E: T+1 wren=1 at the old cursor with in_ascii/in_colour. Cursor advances: x+1; at x=COLS-1, x=0 and y+1; at y=ROWS-1, y wraps to 0.
  - 0x0D (CR): x=0, no write.
  - 0x0A (LF): x=0, y+1 with the same wrap, no write.
  - 0x08 (BS): cursor retreats (x-1; at x=0 go to x=COLS-1, y-1; at (0,0) stay). T+1 wren=1 writes SPACE/CLR_COLOUR at the new cursor.
  - 0x0C (FF): consumed, then S_CLEAR at T+1.
  - All other codes: consumed silently. No write, no highlight change, stay in S_IDLE.
- Handled characters (other than FF):
  - T+1 (S_WRITE): the write above, if any. Simultaneously hien=1, highlight=0 at the old cursor. cur_x/cur_y update at the T+1 edge.
  - T+2 (S_HL_ON): highlight set at the new cursor.
  - T+3: S_IDLE, in_ready=1 again.
  - Maximum throughput is 1 character per 3 cycles.
- clear_req asserted while in S_WRITE or S_HL_ON sets clr_pend; the clear is taken at the next S_IDLE.
- Strobes: wren and hien are high for exactly one cycle per event, except in S_CLEAR. Outputs never leave the active grid.
- Reset mid-operation aborts immediately. Partial writes are not undone; a fresh clear starts after release.

Test Plan:
- Release reset with sL=0 -> wren high for exactly 4800 consecutive cycles, last write at (79,59). Next cycle hien=1, highlight=1 at (0,0). Then in_ready=1.
- In idle, send 'A' (0x41) colour 6'h2A -> T+1: wren, (0,0), 0x41, 6'h2A, plus hien highlight=0 at (0,0). T+2: hien highlight=1 at (1,0). cur_x=1.
- sL=1, cursor at (39,29), send 'Z' -> write at (39,29), cursor wraps to (0,0). Then LF at (5,3) -> cursor (0,4), no wren.
- BS at (0,2) with sL=1 -> cursor (39,1), SPACE written at (39,1). BS at (0,0) -> cursor stays, SPACE written at (0,0).
- Pulse clear_req during S_WRITE -> the current character completes, then the clear starts. in_ready=0 throughout; 1200 writes when sL=1.
- Toggle sL 0->1 mid-clear -> sweep restarts at (0,0) and runs 1200 cycles. Send 0x07 in idle -> consumed, no wren/hien.
